// File: rtl/debounce_pkg.sv
// Shared constants and types for the debounce filter.
// Optional edge pulses are enabled by defining DEBOUNCE_EDGE_PULSE_EN.
package debounce_pkg;

  // 10 ms at 25 MHz
  localparam int unsigned DefaultStableCycles = 250000;

  typedef enum logic {
    ChIdle    = 1'b0,
    ChQualify = 1'b1
  } ch_state_e;

  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchronizer, stability counter, optional edge pulses.
// Edge pulses exist only when DEBOUNCE_EDGE_PULSE_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned StableCycles = DefaultStableCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
`ifdef DEBOUNCE_EDGE_PULSE_EN
  output logic rise_o,
  output logic fall_o,
`endif
  output logic level_o
);

  localparam int unsigned CntW = cnt_width(StableCycles);
  localparam logic [CntW-1:0] CntMax = CntW'(StableCycles - 1);

  logic            sync1_q, sync2_q;
  logic            out_q, out_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any sample matching the committed level discards qualification progress.
  always_comb begin
    out_d = out_q;
    cnt_d = cnt_q;
    if (sync2_q == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      out_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = out_q;

`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic commit;
  logic rise_q, fall_q;

  assign commit = (sync2_q != out_q) && (cnt_q == CntMax);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= commit & sync2_q;
      fall_q <= commit & ~sync2_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`endif

endmodule

// File: rtl/debounce_filter.sv
// WIDTH independent debounce channels for mechanical switch inputs.
// Define DEBOUNCE_EDGE_PULSE_EN to add the rise/fall pulse outputs.
module debounce_filter
  import debounce_pkg::*;
#(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned STABLE_CYCLES = DefaultStableCycles
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_raw,
`ifdef DEBOUNCE_EDGE_PULSE_EN
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
`endif
  output logic [WIDTH-1:0] out
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_channel #(
      .StableCycles(STABLE_CYCLES)
    ) u_ch (
      .clk_i  (clk),
      .rst_i  (rst),
      .raw_i  (in_raw[i]),
`ifdef DEBOUNCE_EDGE_PULSE_EN
      .rise_o (rise[i]),
      .fall_o (fall[i]),
`endif
      .level_o(out[i])
    );
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Directed and random checks of debounce_filter against a run-length reference model.
// Edge pulse checks are included when DEBOUNCE_EDGE_PULSE_EN is defined.
module tb_debounce_filter;

  localparam int unsigned W = 2;
  localparam int unsigned S = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_raw;
  logic [W-1:0] out;
`ifdef DEBOUNCE_EDGE_PULSE_EN
  logic [W-1:0] rise, fall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_filter #(
    .WIDTH        (W),
    .STABLE_CYCLES(S)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .in_raw(in_raw),
`ifdef DEBOUNCE_EDGE_PULSE_EN
    .rise  (rise),
    .fall  (fall),
`endif
    .out   (out)
  );

  // Model: samples reach the filter two edges after the pin; a level is adopted
  // once the most recent S filter samples are all equal and differ from it.
  logic [W-1:0] m_s1, m_s2, m_out, m_rise, m_fall, last_smp;
  int           run [W];

  task automatic model_edge();
    logic [W-1:0] smp;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0; last_smp = '0;
      for (int i = 0; i < W; i++) run[i] = 0;
    end else begin
      smp    = m_s2;
      m_s2   = m_s1;
      m_s1   = in_raw;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (run[i] > 0 && smp[i] == last_smp[i]) begin
          if (run[i] < S) run[i]++;
        end else begin
          run[i] = 1;
        end
        last_smp[i] = smp[i];
        if (run[i] >= S && smp[i] != m_out[i]) begin
          m_out[i] = smp[i];
          if (smp[i]) m_rise[i] = 1'b1;
          else        m_fall[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // One clock edge: update the model, then compare all outputs just after the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("out_vs_model", out, m_out);
`ifdef DEBOUNCE_EDGE_PULSE_EN
    check("rise_vs_model", rise, m_rise);
    check("fall_vs_model", fall, m_fall);
`endif
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    logic [W-1:0] pat [4];
    logic [W-1:0] and_exp;
    pat[0] = 2'b00; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b01;
    and_exp = 2'b00;
    m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0; last_smp = '0;
    for (int i = 0; i < W; i++) run[i] = 0;

    // Reset held with pins high
    rst = 1'b1;
    in_raw = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset_out", out, 2'b00);
`ifdef DEBOUNCE_EDGE_PULSE_EN
      check("reset_rise", rise, 2'b00);
      check("reset_fall", fall, 2'b00);
`endif
    end
    rst = 1'b0;
    ticks(5);
    check("post_reset_e4", out, 2'b00);
    tick();
    check("post_reset_e5", out, 2'b11);

    // Clean press on channel 0
    in_raw = 2'b00;
    ticks(12);
    check("release_all", out, 2'b00);
    in_raw = 2'b01;
    ticks(5);
    check("press_e4", out, 2'b00);
    tick();
    check("press_e5", out, 2'b01);
`ifdef DEBOUNCE_EDGE_PULSE_EN
    check("press_rise", rise, 2'b01);
`endif
    tick();
`ifdef DEBOUNCE_EDGE_PULSE_EN
    check("press_rise_gone", rise, 2'b00);
`endif
    check("press_ch1_low", out, 2'b01);

    // Bounce then hold high
    in_raw = 2'b00;
    ticks(12);
    for (int b = 0; b < 4; b++) begin
      in_raw = (b % 2 == 0) ? 2'b01 : 2'b00;
      ticks(2);
    end
    in_raw = 2'b01;
    ticks(5);
    check("bounce_e4", out, 2'b00);
    tick();
    check("bounce_e5", out, 2'b01);

    // Short low glitch is ignored
    in_raw = 2'b00;
    ticks(3);
    in_raw = 2'b01;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("glitch_hold", out, 2'b01);
    end

    // Reset in the middle of qualifying channel 1
    in_raw = 2'b11;
    ticks(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(2);
    check("midrst_e5", out, 2'b00);
    ticks(3);
    check("midrst_e8", out, 2'b00);
    tick();
    check("midrst_e9", out, 2'b11);

    // Feeding a two-input AND gate
    for (int p = 0; p < 4; p++) begin
      in_raw = pat[p];
      for (int k = 0; k < 20; k++) begin
        tick();
        check("and_vs_model", {1'b0, out[0] & out[1]}, {1'b0, m_out[0] & m_out[1]});
      end
      and_exp = (p == 2) ? 2'b01 : 2'b00;
      check("and_settled", {1'b0, out[0] & out[1]}, and_exp);
    end

    // Random pin activity with occasional resets
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(5) == 0) in_raw[i] = ~in_raw[i];
      end
      rst = ($urandom_range(99) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
